// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush generator for the 5-stage pipeline. It detects load-use
//   hazards, waits out data-memory busy with a timeout, and sequences multi-cycle
//   front-end flushes after branch, trap or mret redirects.
//   The stall/flush outputs are combinational from state + inputs. Only the
//   sequencer state, its counter and the bubble counter are registered.
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_id_valid/rs1/rs2/uses_rs*    ID-stage operand info
//   i_ex_valid/is_load/rd          EX-stage producer info
//   i_redirect/trap_enter/mret     EX-stage PC redirect sources
//   i_mem_busy                     data memory not ready
//   o_*_stall / o_*_flush          pipeline register controls, PC hold
//   o_mem_timeout                  one-cycle pulse when busy outlasts MEM_TIMEOUT
//   o_bubble_cnt                   saturating count of ID/EX bubble cycles
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_redirect,
    input  logic             i_trap_enter,
    input  logic             i_trap_mret,
    input  logic             i_mem_busy,
    output logic             o_pc_stall,
    output logic             o_ifid_stall,
    output logic             o_ifid_flush,
    output logic             o_idex_stall,
    output logic             o_idex_flush,
    output logic             o_exmem_stall,
    output logic             o_exmem_flush,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    localparam int unsigned SEQ_MAX = (MEM_TIMEOUT > FLUSH_CYCLES) ? MEM_TIMEOUT : FLUSH_CYCLES;
    localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;

    logic load_use;
    logic front_redirect;
    logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic exmem_stall, exmem_flush, mem_timeout;

    // Load-use: a load in EX feeds a register ID reads; x0 is never a real dependency
    assign load_use = i_id_valid && i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) &&
                      ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

    assign front_redirect = i_trap_mret || i_redirect;

    // State and sequencer counter (flush countdown or memory-wait count)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            seq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
        end
    end

    // Next-state and raw stall/flush decisions
    always_comb begin
        state_d     = state_q;
        seq_cnt_d   = seq_cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        mem_timeout = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (i_trap_enter || front_redirect) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = i_trap_enter;
                    if (FLUSH_CYCLES > 0) begin
                        state_d   = ST_FLUSH;
                        seq_cnt_d = SEQ_W'(FLUSH_CYCLES);
                    end
                end else if (i_mem_busy) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    state_d     = ST_MEM_WAIT;
                    seq_cnt_d   = SEQ_W'(1);
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end

            // EX is frozen here, so redirect sources are ignored until the wait ends
            ST_MEM_WAIT: begin
                if (i_mem_busy && (seq_cnt_q < SEQ_W'(MEM_TIMEOUT))) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    seq_cnt_d   = seq_cnt_q + SEQ_W'(1);
                end else begin
                    mem_timeout = i_mem_busy;
                    state_d     = ST_RUN;
                    seq_cnt_d   = '0;
                end
            end

            // Fetch is still returning wrong-path words: keep bubbling IF/ID
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                if (i_trap_enter || front_redirect) begin
                    idex_flush  = 1'b1;
                    exmem_flush = i_trap_enter;
                    seq_cnt_d   = SEQ_W'(FLUSH_CYCLES);
                end else if (i_mem_busy) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end else if (seq_cnt_q == SEQ_W'(1)) begin
                    state_d   = ST_RUN;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end

            default: begin
                state_d   = ST_RUN;
                seq_cnt_d = '0;
            end
        endcase
    end

    // Reset forces a full flush; a flush always overrides a stall on the same register
    assign o_pc_stall    = i_rst_n && pc_stall;
    assign o_ifid_flush  = !i_rst_n || ifid_flush;
    assign o_ifid_stall  = i_rst_n && ifid_stall && !ifid_flush;
    assign o_idex_flush  = !i_rst_n || idex_flush;
    assign o_idex_stall  = i_rst_n && idex_stall && !idex_flush;
    assign o_exmem_flush = !i_rst_n || exmem_flush;
    assign o_exmem_stall = i_rst_n && exmem_stall && !exmem_flush;
    assign o_mem_timeout = i_rst_n && mem_timeout;

    // Saturating count of ID/EX bubble cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_cnt_q <= '0;
        end else if (o_idex_flush && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: three parameterisations share one stimulus
// stream; each is compared every cycle against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, uses_rs1, uses_rs2, ex_valid, ex_is_load;
    logic [4:0] rs1, rs2, ex_rd;
    logic       redirect, trap_enter, trap_mret, mem_busy;

    // Output bit order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    // exmem_stall, exmem_flush, mem_timeout
    wire [7:0]  out_a, out_b, out_c;
    wire [15:0] bc_a;
    wire [3:0]  bc_b;
    wire [2:0]  bc_c;

    int checks = 0;
    int errors = 0;
    int timeouts_a;

    // Model parameters per instance: a (FC=2, MT=4), b (FC=1, MT=255), c (FC=0, MT=2)
    int fc [3] = '{2, 1, 0};
    int mt [3] = '{4, 255, 2};
    int cw [3] = '{16, 4, 3};
    int flush_left [3];
    int wait_n     [3];
    int bub        [3];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2), .i_ex_valid(ex_valid),
        .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd), .i_redirect(redirect),
        .i_trap_enter(trap_enter), .i_trap_mret(trap_mret), .i_mem_busy(mem_busy),
        .o_pc_stall(out_a[7]), .o_ifid_stall(out_a[6]), .o_ifid_flush(out_a[5]),
        .o_idex_stall(out_a[4]), .o_idex_flush(out_a[3]), .o_exmem_stall(out_a[2]),
        .o_exmem_flush(out_a[1]), .o_mem_timeout(out_a[0]), .o_bubble_cnt(bc_a));

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2), .i_ex_valid(ex_valid),
        .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd), .i_redirect(redirect),
        .i_trap_enter(trap_enter), .i_trap_mret(trap_mret), .i_mem_busy(mem_busy),
        .o_pc_stall(out_b[7]), .o_ifid_stall(out_b[6]), .o_ifid_flush(out_b[5]),
        .o_idex_stall(out_b[4]), .o_idex_flush(out_b[3]), .o_exmem_stall(out_b[2]),
        .o_exmem_flush(out_b[1]), .o_mem_timeout(out_b[0]), .o_bubble_cnt(bc_b));

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(0), .MEM_TIMEOUT(2), .CNT_W(3)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_rs1(rs1), .i_id_rs2(rs2),
        .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2), .i_ex_valid(ex_valid),
        .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd), .i_redirect(redirect),
        .i_trap_enter(trap_enter), .i_trap_mret(trap_mret), .i_mem_busy(mem_busy),
        .o_pc_stall(out_c[7]), .o_ifid_stall(out_c[6]), .o_ifid_flush(out_c[5]),
        .o_idex_stall(out_c[4]), .o_idex_flush(out_c[3]), .o_exmem_stall(out_c[2]),
        .o_exmem_flush(out_c[1]), .o_mem_timeout(out_c[0]), .o_bubble_cnt(bc_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle of the reference: expected outputs from the current inputs, then advance.
    // flush_left = front-end flush cycles still owed; wait_n = busy cycles stalled so far.
    task automatic model_step(input int k, output logic [7:0] e, output int eb);
        bit lu, flushing;
        e  = 8'h00;
        eb = bub[k];
        if (!rst_n) begin
            e = 8'b0010_1010;
            flush_left[k] = 0;
            wait_n[k]     = 0;
            bub[k]        = 0;
            eb            = 0;
            return;
        end
        lu = id_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
             ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
        if (wait_n[k] > 0) begin
            if (mem_busy && wait_n[k] < mt[k]) begin
                e = 8'b1101_0100;
                wait_n[k]++;
            end else begin
                e[0] = mem_busy;
                wait_n[k] = 0;
            end
        end else begin
            flushing = flush_left[k] > 0;
            if (trap_enter) begin
                e = 8'b0010_1010;
                flush_left[k] = fc[k];
            end else if (trap_mret || redirect) begin
                e = 8'b0010_1000;
                flush_left[k] = fc[k];
            end else if (mem_busy) begin
                e = 8'b1101_0100;
                if (!flushing) wait_n[k] = 1;
            end else if (lu && !flushing) begin
                e = 8'b1100_1000;
            end else if (flushing) begin
                flush_left[k]--;
            end
            if (flushing) begin
                e[5] = 1'b1;
                e[6] = 1'b0;
            end
        end
        if (e[3]) bub[k] = (bub[k] + 1 > (1 << cw[k]) - 1) ? (1 << cw[k]) - 1 : bub[k] + 1;
    endtask

    // Start a cycle: wait for the falling edge and return inputs to idle
    task automatic next();
        @(negedge clk);
        rst_n = 1'b1; id_valid = 0; uses_rs1 = 0; uses_rs2 = 0; ex_valid = 0;
        ex_is_load = 0; rs1 = 0; rs2 = 0; ex_rd = 0;
        redirect = 0; trap_enter = 0; trap_mret = 0; mem_busy = 0;
    endtask

    // Settle, then compare all three instances against the model
    task automatic eval();
        logic [7:0]  e;
        logic [7:0]  o;
        logic [31:0] b;
        int          eb;
        #1;
        timeouts_a += int'(out_a[0]);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin o = out_a; b = 32'(bc_a); end
                1:       begin o = out_b; b = 32'(bc_b); end
                default: begin o = out_c; b = 32'(bc_c); end
            endcase
            model_step(k, e, eb);
            check($sformatf("ctl%0d", k), 32'(o), 32'(e));
            check($sformatf("bub%0d", k), b, 32'(eb));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next();
            eval();
        end
    endtask

    task automatic load_use_cyc(input logic [4:0] rd, input logic [4:0] r2);
        next();
        id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = rd; rs2 = r2; uses_rs2 = 1;
        eval();
    endtask

    initial begin
        timeouts_a = 0;
        // Reset state
        next(); rst_n = 0; eval();
        next(); rst_n = 0; eval();
        idle(1);

        // Load-use on x5 via rs2, then x0 which must not stall
        load_use_cyc(5'd5, 5'd5);
        idle(1);
        check("bub_after_lu", 32'(bc_a), 32'd1);
        load_use_cyc(5'd0, 5'd0);
        idle(1);
        check("bub_after_x0", 32'(bc_a), 32'd1);

        // Memory busy for 3 cycles, then released
        for (int i = 0; i < 3; i++) begin next(); mem_busy = 1; eval(); end
        idle(2);

        // Memory busy stuck high: instance a times out once within 7 cycles
        timeouts_a = 0;
        for (int i = 0; i < 7; i++) begin next(); mem_busy = 1; eval(); end
        check("timeout_pulses_a", 32'(timeouts_a), 32'd1);
        idle(2);

        // Redirect sources during a memory wait are ignored
        next(); mem_busy = 1; eval();
        next(); mem_busy = 1; trap_mret = 1; eval();
        next(); mem_busy = 1; redirect = 1; trap_enter = 1; eval();
        idle(2);

        // Trap for one cycle, then the flush tail
        next(); trap_enter = 1; eval();
        idle(4);

        // Redirect mid-flush reloads the countdown
        next(); trap_enter = 1; eval();
        idle(1);
        next(); redirect = 1; eval();
        idle(4);

        // Busy and load-use during the flush tail
        next(); trap_mret = 1; eval();
        next(); mem_busy = 1; eval();
        load_use_cyc(5'd7, 5'd7);
        idle(3);

        // Reset asserted mid-flush
        next(); trap_enter = 1; eval();
        idle(1);
        next(); rst_n = 0; eval();
        idle(3);

        // Drive the narrow bubble counters into saturation
        for (int i = 0; i < 20; i++) load_use_cyc(5'd3, 5'd3);
        idle(1);
        check("bub_sat_b", 32'(bc_b), 32'd15);
        check("bub_sat_c", 32'(bc_c), 32'd7);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            next();
            rst_n      = ($urandom_range(0, 299) != 0);
            trap_enter = ($urandom_range(0, 19) == 0);
            trap_mret  = ($urandom_range(0, 24) == 0);
            redirect   = ($urandom_range(0, 11) == 0);
            mem_busy   = ($urandom_range(0, 3) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 1) != 0);
            uses_rs1   = ($urandom_range(0, 1) != 0);
            uses_rs2   = ($urandom_range(0, 1) != 0);
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            eval();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
